// File: rtl/data_upload.sv
// ---------------------------------------------------------------------------
// data_upload
//   SPI-slave transmitter that streams a RAM region (tape/snapshot save) back
//   to the IO controller. It shares sck/ss/sdi and the byte framing with the
//   download channel. The SPI lines are oversampled in the clk domain.
//   A req/ack prefetcher keeps one byte ready in 'hold' so that the shifter
//   can load it before the first bit of each byte goes out.
//
// Ports
//   clk, reset    system clock (>= 8x sck), asynchronous active-high reset
//   sck, ss, sdi  SPI from the IO controller (mode 0, ss high = deselected)
//   sdo, sdo_en   SPI data back (MSB first) and its output enable
//   size          bytes valid in the buffer, sampled at upload start
//   uploading     upload session active
//   count         RAM bytes shifted out in the current session
//   rd, a         RAM read request / address (a stable while rd=1)
//   din, rd_ack   RAM read data, valid with the one-cycle acknowledge
// ---------------------------------------------------------------------------
module data_upload #(
  parameter logic [24:0] ADDR_BASE  = 25'h200000,
  parameter logic [7:0]  RD_TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sck,
  input  logic        ss,
  input  logic        sdi,
  output logic        sdo,
  output logic        sdo_en,
  input  logic [24:0] size,
  output logic        uploading,
  output logic [24:0] count,
  output logic        rd,
  output logic [24:0] a,
  input  logic [7:0]  din,
  input  logic        rd_ack
);

  localparam logic [7:0] UIO_FILE_RX     = 8'h56;
  localparam logic [7:0] UIO_FILE_RX_DAT = 8'h57;

  typedef enum logic {PF_IDLE, PF_REQ} pf_state_t;

  // input synchronisers; *_d is one more stage for edge detection
  logic sck_m, sck_s, sck_d;
  logic ss_m, ss_s;
  logic sdi_m, sdi_s;

  logic [3:0]  cnt;
  logic [7:0]  sbuf;
  logic [7:0]  cmd;
  logic [7:0]  shreg;
  logic        load_pending;

  logic [25:0] addr;
  logic [24:0] lim;
  logic [7:0]  hold;
  logic        hold_valid;
  logic        hold_pad;      // hold is end-of-buffer padding, not RAM data
  logic        discard;       // outstanding read belongs to a finished session
  logic [7:0]  timer;
  pf_state_t   state;

  logic        rise, fall;
  logic [7:0]  sbuf_next;
  logic        start_evt, stop_evt;
  logic [25:0] limit;
  logic        in_range;
  logic        rd_timeout, rd_done;

  assign rise      = sck_s & ~sck_d;
  assign fall      = ~sck_s & sck_d;
  assign sbuf_next = {sbuf[6:0], sdi_s};

  // start/stop are decided on the last rise of a UIO_FILE_RX data byte
  assign start_evt = rise && !ss_s && (cnt == 4'd15) && (cmd == UIO_FILE_RX) &&  sbuf_next[0];
  assign stop_evt  = rise && !ss_s && (cnt == 4'd15) && (cmd == UIO_FILE_RX) && !sbuf_next[0];

  // 26-bit end address so a buffer ending at the top of the space cannot wrap
  assign limit    = {1'b0, ADDR_BASE} + {1'b0, lim};
  assign in_range = (addr < limit);

  assign rd_timeout = (state == PF_REQ) && !rd_ack && (timer == RD_TIMEOUT - 8'd1);
  assign rd_done    = (state == PF_REQ) && (rd_ack || rd_timeout);

  assign sdo = shreg[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_m        <= 1'b0;
      sck_s        <= 1'b0;
      sck_d        <= 1'b0;
      ss_m         <= 1'b0;
      ss_s         <= 1'b0;
      sdi_m        <= 1'b0;
      sdi_s        <= 1'b0;
      cnt          <= 4'd0;
      sbuf         <= 8'd0;
      cmd          <= 8'd0;
      shreg        <= 8'd0;
      load_pending <= 1'b0;
      sdo_en       <= 1'b0;
      uploading    <= 1'b0;
      count        <= 25'd0;
      addr         <= {1'b0, ADDR_BASE};
      lim          <= 25'd0;
      hold         <= 8'd0;
      hold_valid   <= 1'b0;
      hold_pad     <= 1'b0;
      discard      <= 1'b0;
      timer        <= 8'd0;
      state        <= PF_IDLE;
      rd           <= 1'b0;
      a            <= ADDR_BASE;
    end else begin
      sck_m <= sck;
      sck_s <= sck_m;
      sck_d <= sck_s;
      ss_m  <= ss;
      ss_s  <= ss_m;
      sdi_m <= sdi;
      sdi_s <= sdi_m;

      // ---------------- prefetch ----------------
      case (state)
        PF_IDLE: begin
          // no launch in the cycle a session starts/stops: addr is being rewritten
          if (uploading && !hold_valid && !start_evt && !stop_evt) begin
            if (in_range) begin
              state <= PF_REQ;
              rd    <= 1'b1;
              a     <= addr[24:0];
              timer <= 8'd0;
            end else begin
              hold       <= 8'h00;
              hold_valid <= 1'b1;
              hold_pad   <= 1'b1;
            end
          end
        end
        PF_REQ: begin
          if (rd_done) begin
            state   <= PF_IDLE;
            rd      <= 1'b0;
            discard <= 1'b0;
            // a read that straddles a session boundary finishes but is dropped
            if (!(discard || start_evt || stop_evt)) begin
              hold       <= rd_ack ? din : 8'hFF;
              hold_valid <= 1'b1;
              hold_pad   <= 1'b0;
              addr       <= addr + 26'd1;
            end
          end else begin
            timer <= timer + 8'd1;
            if (start_evt || stop_evt) begin
              discard <= 1'b1;
            end
          end
        end
        default: state <= PF_IDLE;
      endcase

      // ---------------- framing and shifter ----------------
      if (ss_s) begin
        // deselect wins over a load that is still waiting for its fall
        cnt          <= 4'd0;
        sdo_en       <= 1'b0;
        load_pending <= 1'b0;
      end else begin
        if (rise) begin
          sbuf <= sbuf_next;
          cnt  <= (cnt == 4'd15) ? 4'd8 : cnt + 4'd1;
          if (cnt == 4'd7) begin
            cmd <= sbuf_next;
            if (sbuf_next == UIO_FILE_RX_DAT && uploading) begin
              sdo_en       <= 1'b1;
              load_pending <= 1'b1;
            end
          end
          if (cnt == 4'd15 && sdo_en) begin
            load_pending <= 1'b1;
          end
        end
        if (fall && sdo_en) begin
          if (load_pending) begin
            load_pending <= 1'b0;
            if (hold_valid) begin
              shreg      <= hold;
              hold_valid <= 1'b0;
              if (!hold_pad) begin
                count <= count + 25'd1;
              end
            end else begin
              // underrun: addr is untouched, so the late byte goes out next
              shreg <= 8'hFF;
            end
          end else begin
            shreg <= {shreg[6:0], 1'b0};
          end
        end
      end

      // ---------------- session control ----------------
      if (start_evt) begin
        addr       <= {1'b0, ADDR_BASE};
        lim        <= size;
        count      <= 25'd0;
        uploading  <= 1'b1;
        hold_valid <= 1'b0;
        hold_pad   <= 1'b0;
      end
      if (stop_evt) begin
        uploading <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_data_upload.sv
// ---------------------------------------------------------------------------
// tb_data_upload
//   Bench for data_upload: SPI master model, RAM responder with switchable
//   acknowledge, rd launch monitor and an expected-byte scoreboard.
// ---------------------------------------------------------------------------
module tb_data_upload;

  localparam logic [24:0] BASE = 25'h200000;
  localparam logic [7:0]  TMO  = 8'd40;
  localparam int          H    = 8;       // clk cycles per sck half period

  logic        clk = 1'b0;
  logic        reset;
  logic        sck, ss, sdi;
  logic        sdo, sdo_en;
  logic [24:0] size;
  logic        uploading;
  logic [24:0] count;
  logic        rd;
  logic [24:0] a;
  logic [7:0]  din;
  logic        rd_ack;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:15];
  bit          ack_en;
  bit          en_seen;
  logic [24:0] rd_log[$];
  int          rd_len[$];
  logic [7:0]  exp_q[$];

  typedef struct {
    int          size_v;
    int          nbytes;
    logic [47:0] exp_bytes;   // first byte in the top 8 bits
    int          exp_count;
    int          exp_reads;
  } vec_t;

  vec_t vecs [5];

  data_upload #(.ADDR_BASE(BASE), .RD_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .ss        (ss),
    .sdi       (sdi),
    .sdo       (sdo),
    .sdo_en    (sdo_en),
    .size      (size),
    .uploading (uploading),
    .count     (count),
    .rd        (rd),
    .a         (a),
    .din       (din),
    .rd_ack    (rd_ack)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // RAM responder: acknowledges a request three cycles after it appears
  initial begin
    int lat;
    logic [24:0] off;
    lat    = 0;
    rd_ack = 1'b0;
    din    = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rd_ack) begin
        rd_ack = 1'b0;
        lat    = 0;
      end else if (rd && ack_en) begin
        if (lat == 2) begin
          off    = a - BASE;
          din    = (off < 25'd16) ? mem[off[3:0]] : 8'hEE;
          rd_ack = 1'b1;
          lat    = 0;
        end else begin
          lat++;
        end
      end else begin
        lat = 0;
      end
    end
  end

  // rd monitor: launch addresses and request lengths
  initial begin
    bit prev;
    int len;
    prev = 1'b0;
    len  = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rd && !prev) begin
        rd_log.push_back(a);
        len = 1;
      end else if (rd) begin
        len++;
      end else if (prev) begin
        rd_len.push_back(len);
      end
      prev = rd;
    end
  end

  // One SPI frame: command byte, then nbytes copies of 'data'. The final sck
  // fall and ss rise happen together. When capture is set, each received
  // data byte is compared against the scoreboard head.
  task automatic spi_frame(input logic [7:0] cmd_b, input int nbytes,
                           input logic [7:0] data, input bit capture);
    logic [7:0] cur;
    logic [7:0] rx;
    logic [7:0] exp;
    rx      = 8'h00;
    en_seen = 1'b0;
    ss      = 1'b0;
    tick(H);
    for (int b = 0; b <= nbytes; b++) begin
      cur = (b == 0) ? cmd_b : data;
      for (int i = 7; i >= 0; i--) begin
        sdi = cur[i];
        tick(H);
        rx = {rx[6:0], sdo};
        if (b > 0 && sdo_en) en_seen = 1'b1;
        sck = 1'b1;
        tick(H);
        sck = 1'b0;
        if (b == nbytes && i == 0) ss = 1'b1;
      end
      if (capture && b > 0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sdo_byte: got %h, expected nothing (scoreboard empty)", rx);
        end else begin
          exp = exp_q.pop_front();
          $display("cmd %h byte %0d: sdo=%h expected=%h count=%0d", cmd_b, b, rx, exp, count);
          check("sdo_byte", {24'd0, rx}, {24'd0, exp});
        end
      end
    end
    tick(H);
  endtask

  task automatic start_upload(input int sz);
    size = sz[24:0];
    spi_frame(8'h56, 1, 8'h01, 1'b0);
    check("uploading_after_start", {31'd0, uploading}, 32'd1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [47:0] eb;
    logic [7:0]  c57;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'hFF; mem[3] = 8'h01;
    for (int i = 4; i < 16; i++) mem[i] = 8'h5A;

    vecs[0] = '{4, 4, 48'hA53CFF01_0000, 4, 4};
    vecs[1] = '{4, 6, 48'hA53CFF01_0000, 4, 4};
    vecs[2] = '{2, 4, 48'hA53C0000_0000, 2, 2};
    vecs[3] = '{0, 2, 48'h00000000_0000, 0, 0};
    vecs[4] = '{3, 5, 48'hA53CFF00_0000, 3, 3};

    reset  = 1'b1;
    sck    = 1'b0;
    ss     = 1'b1;
    sdi    = 1'b0;
    size   = 25'd0;
    ack_en = 1'b1;
    tick(3);
    check("reset_sdo",       {31'd0, sdo},       32'd0);
    check("reset_sdo_en",    {31'd0, sdo_en},    32'd0);
    check("reset_uploading", {31'd0, uploading}, 32'd0);
    check("reset_rd",        {31'd0, rd},        32'd0);
    check("reset_count",     {7'd0, count},      32'd0);
    check("reset_a",         {7'd0, a},          {7'd0, BASE});
    reset = 1'b0;
    tick(4);

    // table-driven uploads: start, then one RX_DAT frame
    for (int v = 0; v < 5; v++) begin
      eb = vecs[v].exp_bytes;
      rd_log.delete();
      rd_len.delete();
      start_upload(vecs[v].size_v);
      for (int k = 0; k < vecs[v].nbytes; k++) exp_q.push_back(eb[47 - 8*k -: 8]);
      spi_frame(8'h57, vecs[v].nbytes, 8'h00, 1'b1);
      check("sdo_en_in_data", {31'd0, en_seen}, 32'd1);
      check("count", {7'd0, count}, vecs[v].exp_count);
      check("rd_launches", rd_log.size(), vecs[v].exp_reads);
      for (int k = 0; k < rd_log.size(); k++)
        check("rd_addr", {7'd0, rd_log[k]}, {7'd0, BASE} + k);
    end

    // deselect after two bytes, next frame resumes at the third
    rd_log.delete();
    start_upload(4);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    spi_frame(8'h57, 2, 8'h00, 1'b1);
    check("resume_count_mid", {7'd0, count}, 32'd2);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01);
    spi_frame(8'h57, 2, 8'h00, 1'b1);
    check("resume_count_end", {7'd0, count}, 32'd4);
    check("resume_rd_launches", rd_log.size(), 4);

    // RAM never acknowledges: timed-out bytes read as FF and addr advances
    ack_en = 1'b0;
    rd_log.delete();
    rd_len.delete();
    start_upload(4);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    spi_frame(8'h57, 2, 8'h00, 1'b1);
    check("timeout_count", {7'd0, count}, 32'd2);
    check("timeout_first_addr",  {7'd0, rd_log[0]}, {7'd0, BASE});
    check("timeout_second_addr", {7'd0, rd_log[1]}, {7'd0, BASE} + 32'd1);
    check("timeout_rd_length", rd_len[0], {24'd0, TMO});
    ack_en = 1'b1;
    tick(20);

    // stop mid-stream, then RX_DAT and an unknown command are ignored
    start_upload(4);
    exp_q.push_back(8'hA5);
    spi_frame(8'h57, 1, 8'h00, 1'b1);
    check("stop_count_before", {7'd0, count}, 32'd1);
    spi_frame(8'h56, 1, 8'h00, 1'b0);
    check("stop_uploading", {31'd0, uploading}, 32'd0);
    spi_frame(8'h57, 2, 8'h00, 1'b0);
    check("stop_sdo_en", {31'd0, en_seen}, 32'd0);
    check("stop_count_after", {7'd0, count}, 32'd1);
    spi_frame(8'h55, 1, 8'h01, 1'b0);
    check("cmd55_ignored", {31'd0, uploading}, 32'd0);

    // reset in the middle of a data bit with a read outstanding
    start_upload(4);
    ack_en = 1'b0;
    c57    = 8'h57;
    ss     = 1'b0;
    tick(H);
    for (int i = 7; i >= 0; i--) begin
      sdi = c57[i];
      tick(H);
      sck = 1'b1;
      tick(H);
      sck = 1'b0;
    end
    sdi = 1'b0;
    tick(H);
    sck = 1'b1;
    tick(4);
    check("pre_reset_rd",     {31'd0, rd},     32'd1);
    check("pre_reset_sdo_en", {31'd0, sdo_en}, 32'd1);
    check("pre_reset_sdo",    {31'd0, sdo},    32'd1);
    reset = 1'b1;
    #1;
    check("midreset_sdo",       {31'd0, sdo},       32'd0);
    check("midreset_sdo_en",    {31'd0, sdo_en},    32'd0);
    check("midreset_rd",        {31'd0, rd},        32'd0);
    check("midreset_uploading", {31'd0, uploading}, 32'd0);
    check("midreset_count",     {7'd0, count},      32'd0);
    check("midreset_a",         {7'd0, a},          {7'd0, BASE});
    tick(2);
    sck = 1'b0;
    ss  = 1'b1;
    tick(2);
    reset  = 1'b0;
    ack_en = 1'b1;
    tick(4);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
